// File: rtl/led_pattern_checker_pkg.sv
// Shared definitions for the LED pattern bus monitor: the seven-step code
// table, FSM state encoding and the code-to-step decoder.
package led_pat_pkg;

    localparam int NUM_STEPS = 7;

    localparam logic [7:0] PAT_S0 = 8'h00;
    localparam logic [7:0] PAT_S1 = 8'h18;
    localparam logic [7:0] PAT_S2 = 8'h3C;
    localparam logic [7:0] PAT_S3 = 8'h7E;
    localparam logic [7:0] PAT_S4 = 8'hE7;
    localparam logic [7:0] PAT_S5 = 8'hC3;
    localparam logic [7:0] PAT_S6 = 8'h81;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pat_dec_t;

    // Map a bus value to its step index; anything off the table is invalid.
    function automatic pat_dec_t pat_decode(input logic [7:0] code);
        pat_dec_t d;
        d.valid = 1'b1;
        d.idx   = 3'd0;
        case (code)
            PAT_S0:  d.idx = 3'd0;
            PAT_S1:  d.idx = 3'd1;
            PAT_S2:  d.idx = 3'd2;
            PAT_S3:  d.idx = 3'd3;
            PAT_S4:  d.idx = 3'd4;
            PAT_S5:  d.idx = 3'd5;
            PAT_S6:  d.idx = 3'd6;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Successor step, wrapping after the last code back to the first.
    function automatic logic [2:0] step_next(input logic [2:0] idx);
        return (idx == 3'(NUM_STEPS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/pat_stable_filter.sv
// Input conditioning for the pattern bus: two-flop synchroniser, a stability
// counter that rejects short glitches, and the accepted-value register that
// emits a one-cycle event whenever a new stable value is taken.
module pat_stable_filter #(
    parameter int STABLE_N = 4,
    parameter int W        = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pat_in,
    output logic [W-1:0] acc,
    output logic         acc_vld,
    output logic         acc_evt
);

    localparam int SCNT_W = $clog2(STABLE_N + 1);

    logic [W-1:0]      sync1_reg;
    logic [W-1:0]      pat_s_reg;
    logic [SCNT_W-1:0] scnt_reg;
    logic [SCNT_W-1:0] scnt_next;
    logic [W-1:0]      acc_reg;
    logic              acc_vld_reg;
    logic              acc_evt_reg;
    logic              take;

    // Count consecutive identical synced samples. A change is seen one stage
    // early (first flop vs second) so the count restarts as the new value lands.
    always_comb begin
        scnt_next = scnt_reg;
        if (sync1_reg != pat_s_reg) begin
            scnt_next = '0;
        end else if (scnt_reg != SCNT_W'(STABLE_N)) begin
            scnt_next = scnt_reg + 1'b1;
        end
    end

    // Accept only on the cycle the count reaches its threshold, and only if it differs.
    assign take = (scnt_next == SCNT_W'(STABLE_N)) && (scnt_reg != SCNT_W'(STABLE_N))
                  && (!acc_vld_reg || (pat_s_reg != acc_reg));

    // Synchroniser, stability counter and accepted-value register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg   <= '0;
            pat_s_reg   <= '0;
            scnt_reg    <= '0;
            acc_reg     <= '0;
            acc_vld_reg <= 1'b0;
            acc_evt_reg <= 1'b0;
        end else begin
            sync1_reg   <= pat_in;
            pat_s_reg   <= sync1_reg;
            scnt_reg    <= scnt_next;
            acc_evt_reg <= take;
            if (take) begin
                acc_reg     <= pat_s_reg;
                acc_vld_reg <= 1'b1;
            end
        end
    end

    assign acc     = acc_reg;
    assign acc_vld = acc_vld_reg;
    assign acc_evt = acc_evt_reg;

endmodule

// File: rtl/led_pattern_checker.sv
// Receive-side monitor for the LED pattern bus. Tracks the seven-step
// sequence, locks after a run of in-order steps and reports unknown codes,
// out-of-order steps and stalls, keeping a saturating error count.
module led_pattern_checker
    import led_pat_pkg::*;
#(
    parameter int STABLE_N    = 4,
    parameter int LOCK_N      = 7,
    parameter int TIMEOUT_CYC = 8_000_000,
    parameter int CNT_W       = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pat_in,
    output logic [2:0] step,
    output logic       step_vld,
    output logic       locked,
    output logic       err_code,
    output logic       err_seq,
    output logic       err_stall,
    output logic [7:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);

    logic [7:0]        acc;
    logic              acc_vld;
    logic              acc_evt;
    pat_dec_t          dec;
    fsm_state_t        state_reg;
    logic [2:0]        exp_reg;
    logic [GOOD_W-1:0] good_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [2:0]        step_reg;
    logic              step_vld_reg;
    logic              locked_reg;
    logic              err_code_reg;
    logic              err_seq_reg;
    logic              err_stall_reg;
    logic [7:0]        err_cnt_reg;
    logic              stall_hit;
    logic              err_evt;

    pat_stable_filter #(
        .STABLE_N (STABLE_N),
        .W        (8)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .pat_in  (pat_in),
        .acc     (acc),
        .acc_vld (acc_vld),
        .acc_evt (acc_evt)
    );

    assign dec = pat_decode(acc);

    // A stall only counts when no accepted change arrives in the same cycle.
    assign stall_hit = (state_reg != HUNT) && !acc_evt
                       && (stall_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    // Any decision that raises one of the three error pulses.
    assign err_evt = stall_hit
                     || (acc_evt && (!dec.valid || ((state_reg != HUNT) && (dec.idx != exp_reg))));

    // Sequence FSM, stall timer, registered outputs and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= HUNT;
            exp_reg       <= '0;
            good_reg      <= '0;
            stall_cnt_reg <= '0;
            step_reg      <= '0;
            step_vld_reg  <= 1'b0;
            locked_reg    <= 1'b0;
            err_code_reg  <= 1'b0;
            err_seq_reg   <= 1'b0;
            err_stall_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            step_vld_reg  <= 1'b0;
            err_code_reg  <= 1'b0;
            err_seq_reg   <= 1'b0;
            err_stall_reg <= 1'b0;
            if (acc_evt) begin
                stall_cnt_reg <= '0;
                if (!dec.valid) begin
                    err_code_reg <= 1'b1;
                    locked_reg   <= 1'b0;
                    state_reg    <= HUNT;
                end else if (state_reg == HUNT) begin
                    step_reg     <= dec.idx;
                    step_vld_reg <= 1'b1;
                    exp_reg      <= step_next(dec.idx);
                    good_reg     <= '0;
                    state_reg    <= TRACK;
                end else if (dec.idx == exp_reg) begin
                    step_reg     <= dec.idx;
                    step_vld_reg <= 1'b1;
                    exp_reg      <= step_next(dec.idx);
                    if (state_reg == TRACK) begin
                        good_reg <= good_reg + 1'b1;
                        if (good_reg == GOOD_W'(LOCK_N - 1)) begin
                            state_reg  <= LOCKED;
                            locked_reg <= 1'b1;
                        end
                    end
                end else begin
                    // Out of order: re-anchor on the step actually seen.
                    err_seq_reg  <= 1'b1;
                    step_reg     <= dec.idx;
                    step_vld_reg <= 1'b1;
                    exp_reg      <= step_next(dec.idx);
                    good_reg     <= '0;
                    locked_reg   <= 1'b0;
                    state_reg    <= TRACK;
                end
            end else if (stall_hit) begin
                err_stall_reg <= 1'b1;
                locked_reg    <= 1'b0;
                state_reg     <= HUNT;
                stall_cnt_reg <= '0;
            end else if (state_reg != HUNT) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (err_evt && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign step      = step_reg;
    assign step_vld  = step_vld_reg;
    assign locked    = locked_reg;
    assign err_code  = err_code_reg;
    assign err_seq   = err_seq_reg;
    assign err_stall = err_stall_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
